uart_baud_gen: RTL and testbench

Parametrised, programmable baud/oversample tick generator for the UART RX path, replacing fixed power-of-two clock division with single-cycle clock-enable ticks.
- Produces an oversample tick every DIV system clocks.
- Produces a mid-bit sample tick and an end-of-bit tick from an OS_RATE-deep oversample counter.
- Supports glitch-free divisor reprogramming and phase resync on start-bit detection.
- Sits between the system clock and the RX FSM/sampler; all downstream logic runs on clk qualified by these ticks, with no derived clocks.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_presc.sv | 62 ++++++
 rtl/uart_baud_gen.sv | 65 ++++++
 tb/tb_uart_baud_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART RX constants: oversample rate, divisor width, os index width.
// Used by the baud generator, RX FSM and sampler.
package uart_pkg;
  localparam int UART_OS_RATE = 16;
  localparam int UART_DIV_W   = 16;
  localparam int OS_W         = $clog2(UART_OS_RATE);
endpackage

// File: rtl/uart_presc.sv
// Prescaler with shadow/active divisor and pending flag.
// Ports: clk, rst (sync, active-low), en, div_val, div_load, resync -> term, div_pend.
module uart_presc #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  input  logic             resync,
  output logic             term,
  output logic             div_pend
);

  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] shadow;
  logic [DIV_W-1:0] n_m1;
  logic [DIV_W-1:0] nxt_div;

  // div_act of zero behaves as a divide-by-one
  assign n_m1 = (div_act == '0) ? '0
              : div_act - DIV_W'(1);

  // >= catches a shrink applied while frozen
  assign term = en && (presc >= n_m1);

  // a load in the applying cycle wins over the shadow
  assign nxt_div = div_load ? div_val : shadow;

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc    <= '0;
      div_act  <= DIV_W'(DEFAULT_DIV);
      shadow   <= DIV_W'(DEFAULT_DIV);
      div_pend <= 1'b0;
    end else if (resync) begin
      presc    <= '0;
      div_act  <= nxt_div;
      shadow   <= nxt_div;
      div_pend <= 1'b0;
    end else begin
      if (div_load)
        shadow <= div_val;
      if (term) begin
        presc    <= '0;
        div_act  <= nxt_div;
        div_pend <= 1'b0;
      end else if (en) begin
        presc <= presc + DIV_W'(1);
        if (div_load)
          div_pend <= 1'b1;
      end else begin
        div_act  <= nxt_div;
        div_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// Baud/oversample tick generator: os_tick every N clocks, mid/bit ticks.
// Ports: clk, rst, en, div_val, div_load, resync -> os_tick, mid_tick, bit_tick, os_cnt, div_pend.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W       = UART_DIV_W,
  parameter int OS_RATE     = UART_OS_RATE,
  parameter int DEFAULT_DIV = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [DIV_W-1:0]           div_val,
  input  logic                       div_load,
  input  logic                       resync,
  output logic                       os_tick,
  output logic                       mid_tick,
  output logic                       bit_tick,
  output logic [$clog2(OS_RATE)-1:0] os_cnt,
  output logic                       div_pend
);

  localparam int CW = $clog2(OS_RATE);

  logic term;

  uart_presc #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_presc (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .resync   (resync),
    .term     (term),
    .div_pend (div_pend)
  );

  // os_cnt wraps naturally: OS_RATE is a power of two
  always_ff @(posedge clk) begin
    if (!rst) begin
      os_cnt   <= '0;
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else if (resync) begin
      os_cnt   <= '0;
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else if (term) begin
      os_cnt   <= os_cnt + CW'(1);
      os_tick  <= 1'b1;
      mid_tick <= (os_cnt == CW'(OS_RATE/2 - 1));
      bit_tick <= (os_cnt == CW'(OS_RATE - 1));
    end else begin
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen (DEFAULT_DIV=4, OS_RATE=16).
// Cycle model plus directed literal expectations.
module tb_uart_baud_gen;

  localparam int DW  = 16;
  localparam int OSR = 16;
  localparam int DEF = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] div_val = '0;
  logic          div_load = 1'b0;
  logic          resync = 1'b0;
  logic          os_tick, mid_tick, bit_tick, div_pend;
  logic [3:0]    os_cnt;

  int tests = 0;
  int fails = 0;

  uart_baud_gen #(
    .DIV_W       (DW),
    .OS_RATE     (OSR),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .resync   (resync),
    .os_tick  (os_tick),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick),
    .os_cnt   (os_cnt),
    .div_pend (div_pend)
  );

  always #5 clk = ~clk;

  // Model: elapsed enabled cycles in the current period versus divisor.
  int m_elapsed = 0;
  int m_div = DEF;
  int m_shadow = DEF;
  int m_os = 0;
  bit m_pend = 0;
  bit m_os_t = 0, m_mid_t = 0, m_bit_t = 0;
  bit m_valid = 0;

  always @(posedge clk) begin
    int n;
    if (!rst) begin
      m_elapsed = 0; m_os = 0;
      m_div = DEF; m_shadow = DEF; m_pend = 0;
      m_os_t = 0; m_mid_t = 0; m_bit_t = 0;
      m_valid = 1;
    end else if (resync) begin
      if (div_load) m_shadow = int'(div_val);
      m_div = m_shadow; m_pend = 0;
      m_elapsed = 0; m_os = 0;
      m_os_t = 0; m_mid_t = 0; m_bit_t = 0;
    end else begin
      n = (m_div == 0) ? 1 : m_div;
      if (div_load) m_shadow = int'(div_val);
      m_os_t = 0; m_mid_t = 0; m_bit_t = 0;
      if (en) begin
        m_elapsed++;
        if (m_elapsed >= n) begin
          m_elapsed = 0;
          m_os_t = 1;
          m_mid_t = (m_os == OSR/2 - 1);
          m_bit_t = (m_os == OSR - 1);
          m_os = (m_os + 1) % OSR;
          m_div = m_shadow; m_pend = 0;
        end else if (div_load) begin
          m_pend = 1;
        end
      end else begin
        m_div = m_shadow; m_pend = 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("os_tick", int'(os_tick), int'(m_os_t));
      chk("mid_tick", int'(mid_tick), int'(m_mid_t));
      chk("bit_tick", int'(bit_tick), int'(m_bit_t));
      chk("os_cnt", int'(os_cnt), m_os);
      chk("div_pend", int'(div_pend), int'(m_pend));
    end
  end

  task automatic step(input logic e, input logic ld,
                      input logic [DW-1:0] v,
                      input logic rs, input logic r);
    en = e; div_load = ld; div_val = v;
    resync = rs; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic run1();
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
  endtask

  // enabled edges until os_tick is seen; -1 on timeout
  task automatic until_tick(input string name, output int n);
    n = 0;
    do begin
      run1();
      n++;
    end while (!os_tick && n < 200);
    if (!os_tick) begin
      chk({name, "_timeout"}, 1, 0);
      n = -1;
    end
  endtask

  initial begin
    int f_os, f_mid, f_bit, n, k, c_os, c_mid, c_bit;

    // reset
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("rst_os", int'(os_tick), 0);
    chk("rst_cnt", int'(os_cnt), 0);
    chk("rst_pend", int'(div_pend), 0);

    // default divisor from enable
    f_os = 0; f_mid = 0; f_bit = 0;
    for (int i = 1; i <= 64; i++) begin
      run1();
      if (os_tick && f_os == 0) f_os = i;
      if (mid_tick && f_mid == 0) f_mid = i;
      if (bit_tick && f_bit == 0) f_bit = i;
    end
    chk("first_os", f_os, 4);
    chk("first_mid", f_mid, 32);
    chk("first_bit", f_bit, 64);

    // load 10 at presc=2
    run1(); run1();
    step(1'b1, 1'b1, 16'd10, 1'b0, 1'b1);
    chk("pend_set", int'(div_pend), 1);
    until_tick("cur", n);
    chk("cur_period_tail", n, 1);
    chk("pend_clr", int'(div_pend), 0);
    until_tick("p10a", n);
    chk("period10a", n, 10);
    until_tick("p10b", n);
    chk("period10b", n, 10);

    // resync at os_cnt=5
    k = 0;
    while (os_cnt != 4'd5 && k < 500) begin run1(); k++; end
    chk("reach_os5", int'(os_cnt), 5);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    chk("rs_tick", int'(os_tick), 0);
    chk("rs_cnt", int'(os_cnt), 0);
    until_tick("rs_first", n);
    chk("rs_first", n, 10);
    k = 1;
    while (!mid_tick && k < 20) begin
      until_tick("rs_mid", n);
      k++;
    end
    chk("rs_mid_idx", k, 8);

    // freeze with presc=1
    run1();
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("frz_cnt", int'(os_cnt), 8);
    chk("frz_tick", int'(os_tick), 0);
    until_tick("frz_resume", n);
    chk("frz_resume", n, 9);

    // shrink to 3 while frozen at presc=6
    for (int i = 0; i < 6; i++) run1();
    step(1'b0, 1'b1, 16'd3, 1'b0, 1'b1);
    chk("shr_pend", int'(div_pend), 0);
    until_tick("shr_wrap", n);
    chk("shr_wrap", n, 1);
    until_tick("shr_p3", n);
    chk("shr_p3", n, 3);

    // divisor 0 then 1, each via resync+load
    for (int d = 0; d < 2; d++) begin
      step(1'b0, 1'b1, DW'(d), 1'b1, 1'b1);
      chk("d01_pend", int'(div_pend), 0);
      c_os = 0; c_mid = 0; c_bit = 0;
      for (int i = 0; i < 32; i++) begin
        run1();
        c_os += int'(os_tick);
        c_mid += int'(mid_tick);
        c_bit += int'(bit_tick);
      end
      chk("d01_os", c_os, 32);
      chk("d01_mid", c_mid, 2);
      chk("d01_bit", c_bit, 2);
    end

    // reset with a pending divisor
    step(1'b1, 1'b1, 16'd6, 1'b0, 1'b1);
    run1();
    step(1'b1, 1'b1, 16'd9, 1'b0, 1'b1);
    chk("pre_rst_pend", int'(div_pend), 1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("rst2_os", int'(os_tick), 0);
    chk("rst2_mid", int'(mid_tick), 0);
    chk("rst2_bit", int'(bit_tick), 0);
    chk("rst2_cnt", int'(os_cnt), 0);
    chk("rst2_pend", int'(div_pend), 0);
    until_tick("rst2_def", n);
    chk("rst2_def", n, DEF);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
